// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the wb_stream_master Wishbone initiator.
package wb_stream_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;
  localparam int unsigned DEFAULT_IDX_W     = 8;
  localparam int unsigned REQ_W             = 34 + DEFAULT_IDX_W;
  localparam int unsigned RESP_W            = 33;

  typedef enum logic [1:0] {
    REQ_INSTR = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2,
    REQ_RSVD  = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte address of data word idx; idx is already zero-extended to 32 bits.
  function automatic logic [31:0] data_word_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + 32'd4 + (idx << 2);
  endfunction

endpackage

// File: rtl/wb_stream_master_wb_watchdog.sv
// Bus-cycle watchdog: cleared when a transaction is accepted, counts while the
// initiator sits in BUS and flags expiry on the last allowed cycle.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry fires on the edge that would end the TIMEOUT_CYCLES-th BUS cycle.
  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next count: clear on accept, advance while running and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_stream_master.sv
// Wishbone B4 classic initiator: one val/rdy request becomes one single bus
// cycle (or none for the reserved type) and one val/rdy response.
// Optional feature macro: WB_TIMEOUT_EN (abort a bus cycle with no ack).
module wb_stream_master
  import wb_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int unsigned IDX_W          = DEFAULT_IDX_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i,
  input  logic [IDX_W+33:0] req_msg,
  input  logic              req_val,
  output logic              req_rdy,
  output logic [32:0]       resp_msg,
  output logic              resp_val,
  input  logic              resp_rdy
);

  state_e      state_q;
  logic        cyc_q, we_q, resp_val_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;
  logic [32:0] resp_msg_q;

  req_type_e   req_type;
  logic [31:0] req_data, req_word_adr;
  logic        accept, timeout;

  assign req_type     = req_type_e'(req_msg[IDX_W+33 -: 2]);
  assign req_data     = req_msg[31:0];
  assign req_word_adr = data_word_addr(BASE_ADDR, 32'(req_msg[32 +: IDX_W]));

  // Held low during reset even though the state register already reads IDLE.
  assign req_rdy = (state_q == ST_IDLE) && !wb_rst_i;
  assign accept  = req_val && req_rdy;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign resp_val  = resp_val_q;
  assign resp_msg  = resp_msg_q;

`ifdef WB_TIMEOUT_EN
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clr_i     (accept),
    .run_i     (state_q == ST_BUS),
    .expired_o (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            unique case (req_type)
              REQ_INSTR: begin
                cyc_q   <= 1'b1;
                we_q    <= 1'b1;
                sel_q   <= '1;
                adr_q   <= BASE_ADDR;
                dat_q   <= req_data;
                state_q <= ST_BUS;
              end
              REQ_LOAD: begin
                cyc_q   <= 1'b1;
                we_q    <= 1'b1;
                sel_q   <= '1;
                adr_q   <= req_word_adr;
                dat_q   <= req_data;
                state_q <= ST_BUS;
              end
              REQ_STORE: begin
                cyc_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= '1;
                adr_q   <= req_word_adr;
                dat_q   <= '0;
                state_q <= ST_BUS;
              end
              default: begin
                resp_val_q <= 1'b1;
                resp_msg_q <= {1'b1, 32'h0};
                state_q    <= ST_RESP;
              end
            endcase
          end
        end
        ST_BUS: begin
          if (wbm_ack_i || timeout) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            resp_val_q <= 1'b1;
            state_q    <= ST_RESP;
            if (wbm_ack_i) resp_msg_q <= {1'b0, (we_q ? 32'h0 : wbm_dat_i)};
            else           resp_msg_q <= {1'b1, 32'h0};
          end
        end
        ST_RESP: begin
          if (resp_rdy) begin
            resp_val_q <= 1'b0;
            resp_msg_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_master.sv
// Scoreboard bench for wb_stream_master: directed requests push expected bus
// cycles and responses into queues; slave and response monitors pop and compare.
module tb_wb_stream_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic [41:0] req_msg;
  logic        req_val, req_rdy;
  logic [32:0] resp_msg;
  logic        resp_val, resp_rdy;

  always #5 clk = ~clk;

  wb_stream_master #(
    .BASE_ADDR     (32'h3000_0000),
    .IDX_W         (8),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(dat_i),
    .req_msg  (req_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        bus_q[$];
  logic [32:0] resp_q[$];

  int errors = 0;
  int checks = 0;

  int          ack_delay = 1;   // 0 = slave never acknowledges
  logic [31:0] rd_data   = 32'h0;
  int          last_len  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Slave model plus bus-cycle monitor.
  initial begin
    bus_t cur;
    int   cnt = 0;
    int   len = 0;
    ack   = 1'b0;
    dat_i = 32'hBAD0_BAD0;
    cur   = '{we: 1'b0, adr: 32'h0, dat: 32'h0};
    forever begin
      @(negedge clk);
      if (cyc) len++;
      else if (len != 0) begin
        last_len = len;
        len      = 0;
      end
      if (ack) begin
        ack   = 1'b0;
        dat_i = 32'hBAD0_BAD0;
        cnt   = 0;
        chk("ack_drop_cyc", {63'h0, cyc}, 64'h0);
      end else if (cyc) begin
        if (cnt == 0) begin
          if (bus_q.size() == 0) fail("bus_unexpected");
          else begin
            cur = bus_q.pop_front();
            chk("bus_we",  {63'h0, we},    {63'h0, cur.we});
            chk("bus_adr", {32'h0, adr},   {32'h0, cur.adr});
            chk("bus_dat", {32'h0, dat_o}, {32'h0, cur.dat});
            chk("bus_sel_stb", {59'h0, sel, stb}, {59'h0, 4'hF, 1'b1});
          end
        end else begin
          chk("bus_stable", {31'h0, we, adr}, {31'h0, cur.we, cur.adr});
          chk("bus_stable_dat", {32'h0, dat_o}, {32'h0, cur.dat});
        end
        cnt++;
        if (ack_delay != 0 && cnt == ack_delay) begin
          ack   = 1'b1;
          dat_i = rd_data;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (resp_val && resp_rdy) begin
        if (resp_q.size() == 0) fail("resp_unexpected");
        else begin
          exp = resp_q.pop_front();
          chk("resp_msg", {31'h0, resp_msg}, {31'h0, exp});
        end
      end
    end
  end

  task automatic push_exp(input logic has_bus, input logic e_we, input logic [31:0] e_adr,
                          input logic [31:0] e_dat, input logic [32:0] e_resp);
    if (has_bus) bus_q.push_back('{we: e_we, adr: e_adr, dat: e_dat});
    resp_q.push_back(e_resp);
  endtask

  task automatic send(input logic [1:0] typ, input logic [7:0] idx, input logic [31:0] data);
    int t = 0;
    @(negedge clk);
    req_val = 1'b1;
    req_msg = {typ, idx, data};
    while (!req_rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) fail("req_rdy_timeout");
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0 || resp_val) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;

    // Reset state.
    #12;
    chk("rst_req_rdy",   {63'h0, req_rdy},  64'h0);
    chk("rst_cyc_stb",   {62'h0, cyc, stb}, 64'h0);
    chk("rst_resp_val",  {63'h0, resp_val}, 64'h0);
    chk("rst_resp_msg",  {31'h0, resp_msg}, 64'h0);
    chk("rst_adr_dat_sel", {28'h0, sel, adr ^ dat_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_req_rdy", {63'h0, req_rdy}, 64'h1);

    // INSTR write.
    rd_data = 32'h7777_7777;
    push_exp(1'b1, 1'b1, 32'h3000_0000, 32'h0000_1234, {1'b0, 32'h0});
    send(2'd0, 8'd0, 32'h0000_1234);
    drain();

    // LOAD idx 5, slave acks after 3 cycles.
    ack_delay = 3;
    push_exp(1'b1, 1'b1, 32'h3000_0018, 32'hCAFE_F00D, {1'b0, 32'h0});
    send(2'd1, 8'd5, 32'hCAFE_F00D);
    drain();
    chk("load_cyc_len", 64'(last_len), 64'd3);
    ack_delay = 1;

    // STORE idx 0.
    rd_data = 32'hA5A5_5A5A;
    push_exp(1'b1, 1'b0, 32'h3000_0004, 32'h0, {1'b0, 32'hA5A5_5A5A});
    send(2'd2, 8'd0, 32'h1111_1111);
    drain();

    // Reserved type: no bus cycle.
    push_exp(1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 32'h0});
    send(2'd3, 8'd9, 32'h5555_5555);
    drain();

    // Response back-pressure with a queued follow-on request (STORE idx 255, then INSTR).
    @(posedge clk);
    #2 resp_rdy = 1'b0;
    rd_data = 32'hDEAD_BEEF;
    push_exp(1'b1, 1'b0, 32'h3000_0400, 32'h0, {1'b0, 32'hDEAD_BEEF});
    push_exp(1'b1, 1'b1, 32'h3000_0000, 32'h0000_0042, {1'b0, 32'h0});
    send(2'd2, 8'd255, 32'h0);
    t = 0;
    while (!resp_val && t < 100) begin
      @(negedge clk);
      t++;
    end
    req_val = 1'b1;
    req_msg = {2'd0, 8'd0, 32'h0000_0042};
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_resp_val", {63'h0, resp_val}, 64'h1);
      chk("stall_resp_msg", {31'h0, resp_msg}, {31'h0, 1'b0, 32'hDEAD_BEEF});
      chk("stall_rdy_cyc",  {62'h0, req_rdy, cyc}, 64'h0);
    end
    @(posedge clk);
    #2 resp_rdy = 1'b1;
    t = 0;
    while (!req_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    drain();

    // Reset during an active bus cycle.
    ack_delay = 0;
    push_exp(1'b1, 1'b1, 32'h3000_0008, 32'h0BAD_CAFE, {1'b0, 32'h0});
    send(2'd1, 8'd1, 32'h0BAD_CAFE);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cyc", {63'h0, cyc}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", {62'h0, cyc, stb}, 64'h0);
    chk("midrst_resp_val_rdy", {62'h0, resp_val, req_rdy}, 64'h0);
    resp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    ack_delay = 1;
    rd_data   = 32'h0123_4567;
    push_exp(1'b1, 1'b0, 32'h3000_0010, 32'h0, {1'b0, 32'h0123_4567});
    send(2'd2, 8'd3, 32'h0);
    drain();

`ifdef WB_TIMEOUT_EN
    // Slave never acks: abort after 256 BUS cycles.
    ack_delay = 0;
    push_exp(1'b1, 1'b1, 32'h3000_0008, 32'hFEED_0001, {1'b1, 32'h0});
    send(2'd1, 8'd1, 32'hFEED_0001);
    drain();
    chk("timeout_cyc_len", 64'(last_len), 64'd256);
    ack_delay = 1;
    push_exp(1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 32'h0});
    send(2'd3, 8'd0, 32'h0);
    drain();
`endif

    chk("final_queues", 64'(resp_q.size() + bus_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
